// File: rtl/gf2p8_pkg.sv
// Shared constants and state type for the GF(2^8) divider and field helpers.
package gf2p8_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam logic [7:0] GF_ONE   = 8'h01;
  localparam int         EXP_ITER = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/gf2p8_divider_if.sv
// Request/result bundle for the GF(2^8) divider.
interface gf2p8_divider_if;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic       div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, div_by_zero
  );

endinterface

// File: rtl/gf2p8_mul_poly.sv
// Combinational GF(2^8) multiplier, o = x*y mod (x^8 + POLY).
module gf2p8_mul_poly #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] o
);

  // Shift-and-add: accumulate shifted x, reducing each time bit 7 falls off.
  always_comb begin
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ POLY) : {t[6:0], 1'b0};
    end
    o = acc;
  end

endmodule

// File: rtl/gf2p8_divider.sv
// Sequential GF(2^8) divider: q = a * b^254 via square-and-multiply.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after FIN
// SQR   | s <= s*s
// MUL   | r <= r*s, cnt++; after EXP_ITER pairs go to FIN
// FIN   | q <= r*a_reg, flag divide by zero
module gf2p8_divider
  import gf2p8_pkg::*;
#(
  parameter logic [7:0] POLY = AES_POLY
) (
  input  logic             clk,
  input  logic             rst,
  gf2p8_divider_if.slave   bus
);

  state_t     state, state_nxt;
  logic [7:0] r, s, a_reg;
  logic [2:0] cnt;
  logic [7:0] mul_x, mul_y, mul_o;
  logic       last_iter;

  assign last_iter = (cnt == 3'(EXP_ITER - 1));
  assign bus.busy  = (state != IDLE);

  gf2p8_mul_poly #(.POLY(POLY)) u_mul (
    .x (mul_x),
    .y (mul_y),
    .o (mul_o)
  );

  // Operand selection for the single shared multiplier.
  always_comb begin
    mul_x = s;
    mul_y = s;
    case (state)
      MUL:     begin mul_x = r; mul_y = s;     end
      FIN:     begin mul_x = r; mul_y = a_reg; end
      default: begin mul_x = s; mul_y = s;     end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SQR;
      SQR:     state_nxt = MUL;
      MUL:     state_nxt = last_iter ? FIN : SQR;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers. s holds b^128 in FIN, which is zero
  // exactly when the captured divisor was zero, so no extra flag is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r               <= 8'h00;
      s               <= 8'h00;
      a_reg           <= 8'h00;
      cnt             <= 3'd0;
      bus.q           <= 8'h00;
      bus.div_by_zero <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_reg <= bus.a;
          s     <= bus.b;
          r     <= GF_ONE;
          cnt   <= 3'd0;
        end
        SQR: s <= mul_o;
        MUL: begin
          r   <= mul_o;
          cnt <= cnt + 3'd1;
        end
        FIN: begin
          bus.q           <= mul_o;
          bus.div_by_zero <= (s == 8'h00);
          bus.done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2p8_divider.sv
// Self-checking bench for gf2p8_divider against a long-division field model.
module tb_gf2p8_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  gf2p8_divider_if bus ();

  gf2p8_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Carry-less product followed by polynomial long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    logic [14:0] m;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (y[i]) p = p ^ (15'(x) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) begin
        m = 15'h11B << (k - 8);
        p = p ^ m;
      end
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] y);
    logic [7:0] res;
    res = 8'h00;
    for (int c = 1; c < 256; c++)
      if (ref_mul(8'(c), y) == 8'h01) res = 8'(c);
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE and stop in its done cycle (still IDLE).
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] exp_q, input logic exp_dz, input string tag);
    int cyc;
    int busy_cnt;
    bit seen;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    cyc = 1; busy_cnt = 0; seen = 0;
    while (!seen && cyc < 40) begin
      if (bus.done) seen = 1;
      else begin
        if (bus.busy) busy_cnt++;
        tick();
        cyc++;
      end
    end
    check({tag, "_lat"},  cyc, 16);
    check({tag, "_busy"}, busy_cnt, 15);
    check({tag, "_q"},    bus.q, exp_q);
    check({tag, "_dz"},   bus.div_by_zero, exp_dz);
  endtask

  task automatic do_ref_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
    logic [7:0] e;
    e = (bv == 8'h00) ? 8'h00 : ref_mul(av, ref_inv(bv));
    do_op(av, bv, e, (bv == 8'h00), tag);
  endtask

  initial begin
    int n_done;
    int done_cyc;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q",    bus.q, 0);
    check("rst_dz",   bus.div_by_zero, 0);
    tick();

    do_op(8'h01, 8'h53, 8'hCA, 1'b0, "inv53");
    tick();
    do_op(8'hC1, 8'h83, 8'h57, 1'b0, "divC1_83");
    do_op(8'h57, 8'h01, 8'h57, 1'b0, "b2b_57_01");
    tick();
    do_op(8'h3C, 8'h00, 8'h00, 1'b1, "bzero");
    tick();
    do_op(8'h00, 8'h05, 8'h00, 1'b0, "azero");
    tick();

    // start while busy must be ignored
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h53;
    tick();
    bus.start = 1'b0;
    n_done = 0; done_cyc = 0;
    for (int c = 1; c < 30; c++) begin
      if (c == 5) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; end
      if (c == 6) bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          check("ign_q", bus.q, 8'hCA);
        end
      end
      tick();
    end
    check("ign_ndone", n_done, 1);
    check("ign_cyc",   done_cyc, 16);

    // reset mid-operation
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h53;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_q",    bus.q, 0);
    check("abort_dz",   bus.div_by_zero, 0);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) n_done++;
      tick();
    end
    check("abort_nodone", n_done, 0);
    do_op(8'hC1, 8'h83, 8'h57, 1'b0, "post_abort");
    tick();

    // every nonzero divisor: q must be its inverse
    for (int bv = 1; bv < 256; bv++) begin
      do_ref_op(8'h01, 8'(bv), "sweep");
      check("sweep_inv", ref_mul(bus.q, 8'(bv)), 8'h01);
    end
    tick();

    // random operands, occasionally zero, with random gaps
    for (int i = 0; i < 40; i++) begin
      logic [7:0] av, bv;
      av = 8'($urandom);
      bv = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_ref_op(av, bv, "rand");
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
